// File: rtl/data_memory_read_interface_pkg.sv
// Shared load-path definitions: word type, load funct3 codes, instruction-type bits,
// the stage-5 request payload and the lane-merge helper.
package data_memory_read_interface_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = WORD_W / 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [2:0]        funct3_t;

    localparam funct3_t LOAD_LB  = 3'b000;
    localparam funct3_t LOAD_LH  = 3'b001;
    localparam funct3_t LOAD_LW  = 3'b010;
    localparam funct3_t LOAD_LBU = 3'b100;
    localparam funct3_t LOAD_LHU = 3'b101;

    typedef struct packed {
        logic do_branch;
        logic do_jump;
        logic do_store;
        logic do_load;
        logic do_alu;
    } instr_type_t;

    // Load captured into stage 5 together with its same-cycle store forwarding info
    typedef struct packed {
        logic             valid;
        logic [1:0]       off;
        funct3_t          ftype;
        logic [LANES-1:0] fwd_en;
        word_t            fwd_data;
    } load_req_t;

    function automatic word_t merge_lanes(input word_t raw, input word_t fwd,
                                          input logic [LANES-1:0] en);
        word_t res;
        res = raw;
        for (int i = 0; i < int'(LANES); i++) begin
            if (en[i]) res[i*8 +: 8] = fwd[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_memory_read_interface_load_extend.sv
// Combinational load extraction: picks byte/halfword/word from a merged word,
// sign- or zero-extends it, and flags misaligned or illegal load types.
module data_memory_read_interface_load_extend
    import data_memory_read_interface_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_type,
    output logic [31:0] o_value,
    output logic        o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = 8'(i_word >> {i_off, 3'b000});
        w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_value = '0;
        o_fault = 1'b0;
        case (i_type)
            LOAD_LB:  o_value = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: o_value = {24'b0, w_byte};
            LOAD_LH: begin
                if (i_off[0]) o_fault = 1'b1;
                else          o_value = {{16{w_half[15]}}, w_half};
            end
            LOAD_LHU: begin
                if (i_off[0]) o_fault = 1'b1;
                else          o_value = {16'b0, w_half};
            end
            LOAD_LW: begin
                if (i_off != 2'b00) o_fault = 1'b1;
                else                o_value = i_word;
            end
            default:  o_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_memory_read_interface.sv
// Stage-5 load return path: captures the load beside the synchronous memory read,
// forwards same-cycle same-word store bytes, and holds the word across stalls.
module data_memory_read_interface
    import data_memory_read_interface_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic [ADDR_W-1:0] long_addr,
    input  logic [2:0]        load_type,
    input  logic              store_write,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [3:0]        store_write_to,
    input  logic [31:0]       store_value,
    input  logic [31:0]       mem_read_value,
    input  logic              stall,
    input  logic              flush,
    output logic              load_valid,
    output logic [31:0]       load_value,
    output logic              load_fault
);

    load_req_t r_req;
    word_t     r_hold_word;
    logic      r_held;

    load_req_t w_next_req;
    logic      w_same_word;
    word_t     w_raw;
    word_t     w_merged;
    word_t     w_ext_value;
    logic      w_ext_fault;
    logic      w_unused_store_off;

    // Byte offset of the store is irrelevant: forwarding works at word granularity
    assign w_unused_store_off = ^store_addr[1:0];
    assign w_same_word        = (store_addr[ADDR_W-1:2] == long_addr[ADDR_W-1:2]);

    always_comb begin
        w_next_req          = '0;
        w_next_req.valid    = req_valid & req_is_load & ~flush;
        w_next_req.off      = long_addr[1:0];
        w_next_req.ftype    = load_type;
        w_next_req.fwd_en   = (store_write && w_same_word) ? store_write_to : 4'b0000;
        w_next_req.fwd_data = store_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_req       <= '0;
            r_hold_word <= '0;
            r_held      <= 1'b0;
        end else if (stall) begin
            if (flush) begin
                r_req.valid <= 1'b0;
                r_held      <= 1'b0;
            end else if (!r_held) begin
                r_hold_word <= mem_read_value;
                r_held      <= 1'b1;
            end
        end else begin
            r_req  <= w_next_req;
            r_held <= 1'b0;
        end
    end

    // Memory is re-addressed during a stall, so later stalled cycles use the held copy
    assign w_raw    = r_held ? r_hold_word : mem_read_value;
    assign w_merged = merge_lanes(w_raw, r_req.fwd_data, r_req.fwd_en);

    data_memory_read_interface_load_extend u_load_extend (
        .i_word  (w_merged),
        .i_off   (r_req.off),
        .i_type  (r_req.ftype),
        .o_value (w_ext_value),
        .o_fault (w_ext_fault)
    );

    assign load_valid = r_req.valid;
    assign load_fault = r_req.valid & w_ext_fault;
    assign load_value = (r_req.valid && !w_ext_fault) ? w_ext_value : 32'h0;

endmodule
